// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed 6x6 multiplier:
// FSM state encoding, datapath widths and seven-segment glyphs.
package mult_pkg;

    localparam int OP_W  = 6;
    localparam int RES_W = 12;
    localparam int ITER  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Magnitude of a two's-complement operand; -32 maps to 32 (6'b100000).
    function automatic logic [OP_W-1:0] abs_op(input logic [OP_W-1:0] v);
        logic [OP_W-1:0] r;
        if (v[OP_W-1]) begin
            r = ~v + 6'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal codes blank the digit.
module seg7_decoder
    import mult_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/multiplicador_6_bits.sv
// Sequential signed 6x6 shift-add multiplier with sign-magnitude result.
// Operand magnitudes are multiplied over six iterations; the sign is
// applied as a separate flag, and a zero product is never flagged negative.
// Optional feature macro: MULT_HEX_DISPLAY_EN adds HEX_0..HEX_4 outputs that
// show the result in decimal on five seven-segment digits.
module multiplicador_6_bits
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    input  logic             start,
    output logic [RES_W-1:0] c,
    output logic             neg,
    output logic             done
`ifdef MULT_HEX_DISPLAY_EN
    ,
    output logic [6:0]       HEX_0,
    output logic [6:0]       HEX_1,
    output logic [6:0]       HEX_2,
    output logic [6:0]       HEX_3,
    output logic [6:0]       HEX_4
`endif
);

    state_t           state_r;
    state_t           state_s;
    logic [RES_W-1:0] mcand_r;
    logic [OP_W-1:0]  mplier_r;
    logic [RES_W-1:0] acc_r;
    logic [2:0]       count_r;
    logic             sign_r;
    logic [RES_W-1:0] acc_next_s;
    logic             last_iter_s;

    assign acc_next_s  = acc_r + (mplier_r[0] ? mcand_r : 12'd0);
    assign last_iter_s = (count_r == 3'(ITER - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DONE waits for start to drop so a held request runs once
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: state_s = CALC;
            CALC: begin
                if (last_iter_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (!start) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iterations and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_r  <= 12'd0;
            mplier_r <= 6'd0;
            acc_r    <= 12'd0;
            count_r  <= 3'd0;
            sign_r   <= 1'b0;
            c        <= 12'd0;
            neg      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state_s == DONE);
            case (state_r)
                LOAD: begin
                    mcand_r  <= {6'd0, abs_op(A)};
                    mplier_r <= abs_op(B);
                    sign_r   <= A[OP_W-1] ^ B[OP_W-1];
                    acc_r    <= 12'd0;
                    count_r  <= 3'd0;
                end
                CALC: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r + 3'd1;
                    if (last_iter_s) begin
                        c   <= acc_next_s;
                        neg <= sign_r & (acc_next_s != 12'd0);
                    end else begin
                        c   <= c;
                        neg <= neg;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

`ifdef MULT_HEX_DISPLAY_EN
    logic [15:0] bcd_s;

    // Double-dabble conversion of the registered magnitude to four BCD digits
    always_comb begin
        bcd_s = 16'd0;
        for (int i = RES_W - 1; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (bcd_s[d*4 +: 4] >= 4'd5) begin
                    bcd_s[d*4 +: 4] = bcd_s[d*4 +: 4] + 4'd3;
                end else begin
                    bcd_s[d*4 +: 4] = bcd_s[d*4 +: 4];
                end
            end
            bcd_s = {bcd_s[14:0], c[i]};
        end
    end

    seg7_decoder u_seg0 (.digit(bcd_s[3:0]),   .seg(HEX_0));
    seg7_decoder u_seg1 (.digit(bcd_s[7:4]),   .seg(HEX_1));
    seg7_decoder u_seg2 (.digit(bcd_s[11:8]),  .seg(HEX_2));
    seg7_decoder u_seg3 (.digit(bcd_s[15:12]), .seg(HEX_3));

    assign HEX_4 = neg ? SEG_MINUS : SEG_BLANK;
`endif

endmodule

// File: tb/tb_multiplicador_6_bits.sv
// Directed, scoreboard-based bench for multiplicador_6_bits.
// Optional macro MULT_HEX_DISPLAY_EN enables the display checks.
module tb_multiplicador_6_bits;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  A;
    logic [5:0]  B;
    logic [11:0] c;
    logic        neg;
    logic        done;
`ifdef MULT_HEX_DISPLAY_EN
    logic [6:0]  HEX_0, HEX_1, HEX_2, HEX_3, HEX_4;
`endif

    typedef struct packed {
        logic [11:0] c;
        logic        neg;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [11:0] last_c   = 12'd0;

    always #5 clk = ~clk;

    multiplicador_6_bits dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .start (start),
        .c     (c),
        .neg   (neg),
        .done  (done)
`ifdef MULT_HEX_DISPLAY_EN
        ,
        .HEX_0 (HEX_0),
        .HEX_1 (HEX_1),
        .HEX_2 (HEX_2),
        .HEX_3 (HEX_3),
        .HEX_4 (HEX_4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one operation, pop the expected result when done rises.
    task automatic run_op(input logic [5:0] a, input logic [5:0] b,
                          input int hold, input bit scramble);
        exp_t e;
        int   sa, sb, prod, lat;
        bit   seen;
        sa   = {{26{a[5]}}, a};
        sb   = {{26{b[5]}}, b};
        prod = sa * sb;
        e.neg = (prod < 0);
        e.c   = 12'((prod < 0) ? -prod : prod);
        sb_q.push_back(e);

        @(negedge clk);
        A = a; B = b; start = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 3) begin
                check("c_held_during_calc", c, last_c);
                if (scramble) begin
                    A = 6'($urandom);
                    B = 6'($urandom);
                end
            end
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        check("latency", lat - 1, 7);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("c", c, e.c);
            check("neg", neg, e.neg);
            last_c = e.c;
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check("done_held", done, 1);
            check("c_no_retrigger", c, e.c);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("done_cleared", done, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; A = 6'd0; B = 6'd0;
        #1;
        check("rst_c", c, 0);
        check("rst_neg", neg, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 9 * -7, start held 15 cycles, operands scrambled mid-CALC
        run_op(6'd9, 6'b111001, 7, 1'b1);
`ifdef MULT_HEX_DISPLAY_EN
        check("hex4_minus", HEX_4, 7'b0111111);
        check("hex3_zero",  HEX_3, 7'b1000000);
        check("hex2_zero",  HEX_2, 7'b1000000);
        check("hex1_six",   HEX_1, 7'b0000010);
        check("hex0_three", HEX_0, 7'b0110000);
`endif
        run_op(6'b101000, 6'd5, 0, 1'b1);
        run_op(6'b100000, 6'b100000, 0, 1'b0);
        run_op(6'd31, 6'd31, 0, 1'b0);

        // Reset in the middle of CALC
        @(negedge clk);
        A = 6'd3; B = 6'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_c", c, 0);
        check("midrst_neg", neg, 0);
        check("midrst_done", done, 0);
        last_c = 12'd0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_rst", done, 0);

        run_op(6'b111111, 6'd31, 0, 1'b0);
        run_op(6'd0, 6'b111011, 0, 1'b0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
